// File: rtl/puf_ctrl_pkg.sv
// ============================================================================
// Module      : puf_ctrl_pkg
// Description : Shared types and default timing constants for the arbiter-PUF
//               evaluation controller (state encoding, timer sizing helper).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package puf_ctrl_pkg;

  // Controller states; explicit 3-bit encoding
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DISCHARGE = 3'd1,
    LAUNCH    = 3'd2,
    SAMPLE    = 3'd3,
    DONE      = 3'd4
  } puf_state_e;

  // Default timing / geometry constants
  localparam int c_DEF_N_STAGES   = 64;
  localparam int c_DEF_RESET_CYC  = 4;
  localparam int c_DEF_SETTLE_CYC = 8;
  localparam int c_DEF_REPEATS    = 5;

  // Width of a down-counter that must hold values up to max(a,b)-1 (at least 1 bit)
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage : puf_ctrl_pkg

`default_nettype wire

// File: rtl/puf_sync2.sv
// ============================================================================
// Module      : puf_sync2
// Description : Two-flop synchroniser for the asynchronous arbiter latch
//               output; both flops clear to 0 on synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module puf_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule : puf_sync2

`default_nettype wire

// File: rtl/puf_eval_ctrl.sv
// ============================================================================
// Module      : puf_eval_ctrl
// Description : Sequences challenge/response evaluations of an arbiter-PUF
//               mux chain: latch challenge onto selects, discharge the chain,
//               launch an edge, wait for settling, sample the synchronised
//               arbiter output and return the bit over valid/ready.
//               Optional feature macro: PUF_MAJORITY_VOTE_EN (repeat the
//               evaluation REPEATS times and majority-vote the response).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import puf_ctrl_pkg::*;

module puf_eval_ctrl #(
  parameter int N_STAGES   = c_DEF_N_STAGES,
  parameter int RESET_CYC  = c_DEF_RESET_CYC,
  parameter int SETTLE_CYC = c_DEF_SETTLE_CYC,
  parameter int REPEATS    = c_DEF_REPEATS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                chal_valid,
  output logic                chal_ready,
  input  logic [N_STAGES-1:0] challenge,
  output logic [N_STAGES-1:0] sel,
  output logic                launch,
  input  logic                arb_in,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp,
  output logic                resp_stable,
  output logic                busy
);

  localparam int c_TW = timer_width(RESET_CYC, SETTLE_CYC);
  localparam logic [c_TW-1:0] c_DIS_LOAD = c_TW'(RESET_CYC - 1);
  localparam logic [c_TW-1:0] c_SET_LOAD = c_TW'(SETTLE_CYC - 1);

  puf_state_e          r_state;
  logic [N_STAGES-1:0] r_sel;
  logic                r_launch;
  logic                r_resp_valid;
  logic                r_resp;
  logic [c_TW-1:0]     r_timer;
  logic                w_arb_sync;

  // arb_in is only ever observed through this synchroniser
  puf_sync2 u_arb_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (arb_in),
    .o_sync  (w_arb_sync)
  );

`ifdef PUF_MAJORITY_VOTE_EN
  localparam int c_CW = $clog2(REPEATS + 1);
  localparam logic [c_CW-1:0] c_LAST_REP = c_CW'(REPEATS - 1);
  localparam logic [c_CW-1:0] c_HALF     = c_CW'(REPEATS / 2);
  localparam logic [c_CW-1:0] c_ALL      = c_CW'(REPEATS);

  logic [c_CW-1:0] r_ones;
  logic [c_CW-1:0] r_rep;
  logic            r_resp_stable;
  logic [c_CW-1:0] w_ones_next;

  // Running ones count including the bit being sampled this cycle
  assign w_ones_next = r_ones + c_CW'(w_arb_sync);
`endif

  // Evaluation sequencer: state, select lines, launch edge, timers and response
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_sel        <= '0;
      r_launch     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp       <= 1'b0;
      r_timer      <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
      r_ones        <= '0;
      r_rep         <= '0;
      r_resp_stable <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (chal_valid) begin
            r_sel   <= challenge;
            r_timer <= c_DIS_LOAD;
            r_state <= DISCHARGE;
`ifdef PUF_MAJORITY_VOTE_EN
            r_ones  <= '0;
            r_rep   <= '0;
`endif
          end
        end

        DISCHARGE: begin
          if (r_timer == '0) begin
            r_launch <= 1'b1;
            r_timer  <= c_SET_LOAD;
            r_state  <= LAUNCH;
          end else begin
            r_timer <= r_timer - c_TW'(1);
          end
        end

        // Launch drops on entry to SAMPLE so the edge is high for exactly SETTLE_CYC cycles
        LAUNCH: begin
          if (r_timer == '0) begin
            r_launch <= 1'b0;
            r_state  <= SAMPLE;
          end else begin
            r_timer <= r_timer - c_TW'(1);
          end
        end

        SAMPLE: begin
          r_launch <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
          r_ones <= w_ones_next;
          r_rep  <= r_rep + c_CW'(1);
          if (r_rep == c_LAST_REP) begin
            r_resp        <= (w_ones_next > c_HALF);
            r_resp_stable <= (w_ones_next == '0) || (w_ones_next == c_ALL);
            r_state       <= DONE;
          end else begin
            r_timer <= c_DIS_LOAD;
            r_state <= DISCHARGE;
          end
`else
          r_resp  <= w_arb_sync;
          r_state <= DONE;
`endif
        end

        // resp_valid rises one cycle into DONE and only falls on a handshake
        DONE: begin
          if (!r_resp_valid) begin
            r_resp_valid <= 1'b1;
          end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign chal_ready = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign sel        = r_sel;
  assign launch     = r_launch;
  assign resp_valid = r_resp_valid;
  assign resp       = r_resp;
`ifdef PUF_MAJORITY_VOTE_EN
  assign resp_stable = r_resp_stable;
`else
  assign resp_stable = 1'b1;
`endif

endmodule : puf_eval_ctrl

`default_nettype wire
